// File: rtl/txn_delay_slave.sv
// txn_delay_slave
// ---------------
// Memory-backed AXI-like slave with a programmable response latency. Reads are
// queued (up to DEPTH outstanding) and answered in order; writes are handled one
// at a time by a small FSM. Both paths share the word memory but are otherwise
// independent, so AR and AW may be accepted in the same cycle.
//
// Ports
//   clk, rst                     : clock (rising edge) and synchronous active-high reset
//   delay[4:0]                   : response latency, captured per AR and per last W beat
//   ar*  (arvalid/arready/arid/araddr/arlen)        : read address channel
//   r*   (rvalid/rready/rdata/rid/rlast/rresp)      : read data channel
//   aw*  (awvalid/awready/awid/awaddr/awlen)        : write address channel
//   w*   (wvalid/wready/wdata/wlast)                : write data channel
//   b*   (bvalid/bready/bid/bresp)                  : write response channel
//   ridle, widle                 : read queue empty / write FSM idle
//
// Build option
//   TXN_DELAY_SLAVE_BOUND_CHECK_EN : when defined, bursts running past the top of
//   the address space answer SLVERR and their out-of-range writes are dropped;
//   when undefined, addresses wrap silently with OKAY.
module txn_delay_slave #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        delay,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [ID_W-1:0]   rid,
  output logic              rlast,
  output logic [1:0]        rresp,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              ridle,
  output logic              widle
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = ADDR_W + LEN_W + 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wstate_t;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // read queue storage and control
  logic [ID_W-1:0]   r_qId   [DEPTH];
  logic [ADDR_W-1:0] r_qAddr [DEPTH];
  logic [LEN_W-1:0]  r_qLen  [DEPTH];
  logic [4:0]        r_qDly  [DEPTH];
  logic [PW-1:0]     r_wrPtr, r_rdPtr;
  logic [PW:0]       r_qCount;
  logic              r_headLive;
  logic [4:0]        r_rCnt;
  logic [LEN_W-1:0]  r_rBeat;
  logic              r_rHold;
  logic [DATA_W-1:0] r_rHoldData;

  logic              w_qEmpty, w_qFull, w_arHs, w_rValid, w_rHs, w_rLast, w_pop;
  logic [ADDR_W-1:0] w_rAddr;
  logic [DATA_W-1:0] w_rMemData;
  logic [1:0]        w_rResp;

  // write path state
  wstate_t           r_wState, w_wNext;
  logic [ID_W-1:0]   r_awId;
  logic [ADDR_W-1:0] r_awAddr;
  logic [LEN_W-1:0]  r_awLen;
  logic [LEN_W-1:0]  r_wBeat;
  logic [4:0]        r_wCnt;
  logic [1:0]        r_bresp;

  logic              w_awHs, w_wHs, w_wAtLen, w_wLastBeat, w_wErr, w_wSuppress;
  logic [ADDR_W-1:0] w_wAddr;

  // Read-side handshakes and head-of-queue decode. The head only presents data
  // once its captured delay has fully counted down after it reached the head.
  assign w_qEmpty   = (r_qCount == '0);
  assign w_qFull    = (r_qCount == (PW+1)'(DEPTH));
  assign w_arHs     = arvalid && !rst && !w_qFull;
  assign w_rValid   = !rst && !w_qEmpty && r_headLive && (r_rCnt == 5'd0);
  assign w_rHs      = w_rValid && rready;
  assign w_rLast    = (r_rBeat == r_qLen[r_rdPtr]);
  assign w_pop      = w_rHs && w_rLast;
  assign w_rAddr    = r_qAddr[r_rdPtr] + ADDR_W'(r_rBeat);
  assign w_rMemData = r_mem[w_rAddr];

  // Address overflow detection only exists when the bound check is built in;
  // otherwise the beat address simply wraps and every response is OKAY.
`ifdef TXN_DELAY_SLAVE_BOUND_CHECK_EN
  localparam logic [SW-1:0] ADDR_MAX = SW'((2**ADDR_W) - 1);
  assign w_rResp     = ((SW'(r_qAddr[r_rdPtr]) + SW'(r_qLen[r_rdPtr])) > ADDR_MAX) ? 2'b10 : 2'b00;
  assign w_wSuppress = (SW'(r_awAddr) + SW'(r_wBeat)) > ADDR_MAX;
  assign w_wErr      = (w_wAtLen != wlast) || ((SW'(r_awAddr) + SW'(r_awLen)) > ADDR_MAX);
`else
  assign w_rResp     = 2'b00;
  assign w_wSuppress = 1'b0;
  assign w_wErr      = (w_wAtLen != wlast);
`endif

  // Read channel outputs are zeroed whenever no beat is offered. rdata comes
  // straight from memory (so a same-cycle write is not seen) but is frozen
  // once a stalled beat has been shown, keeping it stable until accepted.
  assign arready = !rst && !w_qFull;
  assign rvalid  = w_rValid;
  assign rdata   = w_rValid ? (r_rHold ? r_rHoldData : w_rMemData) : '0;
  assign rid     = w_rValid ? r_qId[r_rdPtr] : '0;
  assign rlast   = w_rValid && w_rLast;
  assign rresp   = w_rValid ? w_rResp : 2'b00;
  assign ridle   = rst || w_qEmpty;

  // Queue payload slots carry no reset; the pointers and count decide validity.
  always_ff @(posedge clk) begin
    if (w_arHs) begin
      r_qId[r_wrPtr]   <= arid;
      r_qAddr[r_wrPtr] <= araddr;
      r_qLen[r_wrPtr]  <= arlen;
      r_qDly[r_wrPtr]  <= delay;
    end
  end

  // Queue pointers plus the head sequencer. A new head spends one cycle loading
  // its delay, then counts down to zero before beats flow; popping on the last
  // accepted beat hands over to the next entry in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_qCount    <= '0;
      r_headLive  <= 1'b0;
      r_rCnt      <= 5'd0;
      r_rBeat     <= '0;
      r_rHold     <= 1'b0;
      r_rHoldData <= '0;
    end else begin
      if (w_arHs) r_wrPtr <= r_wrPtr + PW'(1);
      case ({w_arHs, w_pop})
        2'b10:   r_qCount <= r_qCount + (PW+1)'(1);
        2'b01:   r_qCount <= r_qCount - (PW+1)'(1);
        default: r_qCount <= r_qCount;
      endcase
      if (w_pop) begin
        r_rdPtr    <= r_rdPtr + PW'(1);
        r_headLive <= 1'b0;
        r_rBeat    <= '0;
      end else if (w_rHs) begin
        r_rBeat <= r_rBeat + LEN_W'(1);
      end else if (!w_qEmpty && !r_headLive) begin
        r_headLive <= 1'b1;
        r_rCnt     <= r_qDly[r_rdPtr];
      end else if (r_headLive && (r_rCnt != 5'd0)) begin
        r_rCnt <= r_rCnt - 5'd1;
      end
      if (w_rHs) begin
        r_rHold <= 1'b0;
      end else if (w_rValid && !r_rHold) begin
        r_rHold     <= 1'b1;
        r_rHoldData <= w_rMemData;
      end
    end
  end

  // Write-side handshakes and beat decode. A burst ends on whichever comes
  // first: the beat count implied by awlen or the master's wlast.
  assign w_awHs      = awvalid && !rst && (r_wState == W_IDLE);
  assign w_wHs       = wvalid && !rst && (r_wState == W_DATA);
  assign w_wAtLen    = (r_wBeat == r_awLen);
  assign w_wLastBeat = w_wAtLen || wlast;
  assign w_wAddr     = r_awAddr + ADDR_W'(r_wBeat);

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_wState <= W_IDLE;
    else     r_wState <= w_wNext;
  end

  // Write FSM next state and channel outputs. A zero delay skips W_WAIT and
  // raises the response right after the last beat.
  always_comb begin
    w_wNext = r_wState;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bid     = '0;
    bresp   = 2'b00;
    widle   = rst || (r_wState == W_IDLE);
    case (r_wState)
      W_IDLE: begin
        awready = !rst;
        if (w_awHs) w_wNext = W_DATA;
      end
      W_DATA: begin
        wready = !rst;
        if (w_wHs && w_wLastBeat) w_wNext = (delay == 5'd0) ? W_RESP : W_WAIT;
      end
      W_WAIT: begin
        if (r_wCnt <= 5'd1) w_wNext = W_RESP;
      end
      W_RESP: begin
        bvalid = !rst;
        bid    = rst ? '0 : r_awId;
        bresp  = rst ? 2'b00 : r_bresp;
        if (bready) w_wNext = W_IDLE;
      end
      default: w_wNext = W_IDLE;
    endcase
  end

  // Write burst bookkeeping: address context, beat index, wait counter and the
  // response code decided when the last beat lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_awId   <= '0;
      r_awAddr <= '0;
      r_awLen  <= '0;
      r_wBeat  <= '0;
      r_wCnt   <= 5'd0;
      r_bresp  <= 2'b00;
    end else begin
      if (w_awHs) begin
        r_awId   <= awid;
        r_awAddr <= awaddr;
        r_awLen  <= awlen;
        r_wBeat  <= '0;
      end
      if (w_wHs) begin
        r_wBeat <= r_wBeat + LEN_W'(1);
        if (w_wLastBeat) begin
          r_wCnt  <= delay;
          r_bresp <= w_wErr ? 2'b10 : 2'b00;
        end
      end
      if (r_wState == W_WAIT) r_wCnt <= r_wCnt - 5'd1;
    end
  end

  // Memory is never cleared; data survives reset so it can be read back later.
  always_ff @(posedge clk) begin
    if (w_wHs && !w_wSuppress) r_mem[w_wAddr] <= wdata;
  end

endmodule

// File: tb/tb_txn_delay_slave.sv
// Directed bench for txn_delay_slave: one task per scenario, expected values
// worked out by hand from the intended cycle behaviour of the slave.
module tb_txn_delay_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] delay;
  logic       arvalid, arready, rvalid, rready, rlast;
  logic [3:0] arid, rid, awid, bid, arlen, awlen;
  logic [7:0] araddr, awaddr, rdata, wdata;
  logic [1:0] rresp, bresp;
  logic       awvalid, awready, wvalid, wready, wlast, bvalid, bready, ridle, widle;

  int checks = 0;
  int errors = 0;

`ifdef TXN_DELAY_SLAVE_BOUND_CHECK_EN
  localparam logic [1:0] EXP_WRAP_RESP = 2'b10;
  localparam logic [7:0] EXP_WRAP_D1   = 8'h77;
`else
  localparam logic [1:0] EXP_WRAP_RESP = 2'b00;
  localparam logic [7:0] EXP_WRAP_D1   = 8'hC3;
`endif

  txn_delay_slave dut (
    .clk(clk), .rst(rst), .delay(delay),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rlast(rlast), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .ridle(ridle), .widle(widle)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    delay = 5'd0; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; rready = 1'b0;
    awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0;
    wvalid = 1'b0; wdata = '0; wlast = 1'b0; bready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleInputs();
    tick();
    tick();
    checks++;
    if ({arready, awready, wready, rvalid, rlast, bvalid, ridle, widle} !== 8'b0000_0011) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000011",
               {arready, awready, wready, rvalid, rlast, bvalid, ridle, widle});
    end
    checks++;
    if ({rdata, rid, rresp, bid, bresp} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_payload: got %h expected 00000", {rdata, rid, rresp, bid, bresp});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({arready, awready} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %b expected 11", {arready, awready});
    end
  endtask

  task automatic test_write_delay();
    int n;
    delay = 5'd10; awvalid = 1'b1; awid = 4'd4; awaddr = 8'h10; awlen = 4'd1;
    #1;
    checks++;
    if (awready !== 1'b1) begin errors++; $display("[TB] FAIL aw_ready: got %b expected 1", awready); end
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 8'hA1; wlast = 1'b0;
    #1;
    checks++;
    if (wready !== 1'b1) begin errors++; $display("[TB] FAIL w_ready: got %b expected 1", wready); end
    tick();
    wdata = 8'hA2; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 60) begin tick(); n++; end
    checks++;
    if (n != 10) begin errors++; $display("[TB] FAIL b_latency: got %0d expected 10", n); end
    checks++;
    if ({bid, bresp} !== {4'd4, 2'b00}) begin
      errors++; $display("[TB] FAIL b_payload: got %h/%b expected 4/00", bid, bresp);
    end
    tick();
    checks++;
    if ({bvalid, bid} !== {1'b1, 4'd4}) begin
      errors++; $display("[TB] FAIL b_hold: got %b/%h expected 1/4", bvalid, bid);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if ({bvalid, widle} !== 2'b01) begin
      errors++; $display("[TB] FAIL b_done: got %b expected 01", {bvalid, widle});
    end
  endtask

  task automatic test_read_delay();
    int n;
    delay = 5'd20; arvalid = 1'b1; arid = 4'd5; araddr = 8'h10; arlen = 4'd1;
    #1;
    checks++;
    if (arready !== 1'b1) begin errors++; $display("[TB] FAIL ar_ready: got %b expected 1", arready); end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 60) begin tick(); n++; end
    checks++;
    if (n != 21) begin errors++; $display("[TB] FAIL r_latency: got %0d expected 21", n); end
    checks++;
    if ({rdata, rid, rlast, rresp} !== {8'hA1, 4'd5, 1'b0, 2'b00}) begin
      errors++; $display("[TB] FAIL r_beat0: got %h/%h/%b/%b expected a1/5/0/00", rdata, rid, rlast, rresp);
    end
    tick();
    checks++;
    if ({rvalid, rdata, rid} !== {1'b1, 8'hA1, 4'd5}) begin
      errors++; $display("[TB] FAIL r_hold: got %b/%h/%h expected 1/a1/5", rvalid, rdata, rid);
    end
    rready = 1'b1;
    tick();
    checks++;
    if ({rvalid, rdata, rid, rlast} !== {1'b1, 8'hA2, 4'd5, 1'b1}) begin
      errors++; $display("[TB] FAIL r_beat1: got %b/%h/%h/%b expected 1/a2/5/1", rvalid, rdata, rid, rlast);
    end
    tick();
    rready = 1'b0;
    checks++;
    if ({rvalid, ridle} !== 2'b01) begin
      errors++; $display("[TB] FAIL r_done: got %b expected 01", {rvalid, ridle});
    end
  endtask

  task automatic test_queue_full();
    int n;
    int got;
    logic sawReady;
    logic [3:0] ids [4];
    delay = 5'd3; rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      arvalid = 1'b1; arid = 4'(i); araddr = 8'h10; arlen = 4'd0;
      #1;
      checks++;
      if (arready !== 1'b1) begin errors++; $display("[TB] FAIL ar_fill%0d: got %b expected 1", i, arready); end
      tick();
    end
    arid = 4'd4;
    #1;
    checks++;
    if (arready !== 1'b0) begin errors++; $display("[TB] FAIL ar_full: got %b expected 0", arready); end
    sawReady = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 40) begin
      if (arready !== 1'b0) sawReady = 1'b1;
      tick();
      n++;
    end
    checks++;
    if ({rvalid, rid, sawReady} !== {1'b1, 4'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL first_head: got %b/%h/%b expected 1/0/0", rvalid, rid, sawReady);
    end
    rready = 1'b1;
    #1;
    checks++;
    if (arready !== 1'b0) begin errors++; $display("[TB] FAIL ar_full_pop: got %b expected 0", arready); end
    tick();
    checks++;
    if (arready !== 1'b1) begin errors++; $display("[TB] FAIL ar_after_pop: got %b expected 1", arready); end
    tick();
    arvalid = 1'b0;
    for (int k = 0; k < 4; k++) ids[k] = 4'hF;
    got = 0;
    n = 0;
    while (got < 4 && n < 100) begin
      if (rvalid === 1'b1) begin ids[got] = rid; got++; end
      tick();
      n++;
    end
    rready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ids[k] !== 4'(k + 1)) begin
        errors++; $display("[TB] FAIL order%0d: got %h expected %0d", k, ids[k], k + 1);
      end
    end
  endtask

  task automatic test_wlast_early();
    delay = 5'd0; awvalid = 1'b1; awid = 4'd7; awaddr = 8'h40; awlen = 4'd3;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 8'h11; wlast = 1'b0;
    tick();
    wdata = 8'h22; wlast = 1'b1;
    tick();
    wdata = 8'h33; wlast = 1'b0;
    #1;
    checks++;
    if (wready !== 1'b0) begin errors++; $display("[TB] FAIL extra_beat: got %b expected 0", wready); end
    checks++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd7, 2'b10}) begin
      errors++; $display("[TB] FAIL early_resp: got %b/%h/%b expected 1/7/10", bvalid, bid, bresp);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0; wvalid = 1'b0;
    checks++;
    if ({widle, awready, wready} !== 3'b110) begin
      errors++; $display("[TB] FAIL early_idle: got %b expected 110", {widle, awready, wready});
    end
  endtask

  task automatic test_reset_mid();
    int n;
    delay = 5'd0; arvalid = 1'b1; arid = 4'd9; araddr = 8'h10; arlen = 4'd1;
    tick();
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin tick(); n++; end
    rready = 1'b1;
    tick();
    checks++;
    if ({rvalid, rdata} !== {1'b1, 8'hA2}) begin
      errors++; $display("[TB] FAIL mid_burst: got %b/%h expected 1/a2", rvalid, rdata);
    end
    rst = 1'b1; rready = 1'b0;
    tick();
    checks++;
    if ({rvalid, ridle} !== 2'b01) begin
      errors++; $display("[TB] FAIL reset_mid: got %b expected 01", {rvalid, ridle});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({rvalid, ridle} !== 2'b01) begin
      errors++; $display("[TB] FAIL after_reset_mid: got %b expected 01", {rvalid, ridle});
    end
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (rdata !== 8'hA1) begin errors++; $display("[TB] FAIL reread0: got %h expected a1", rdata); end
    rready = 1'b1;
    tick();
    checks++;
    if ({rdata, rlast} !== {8'hA2, 1'b1}) begin
      errors++; $display("[TB] FAIL reread1: got %h/%b expected a2/1", rdata, rlast);
    end
    tick();
    rready = 1'b0;
  endtask

  task automatic test_wrap();
    int n;
    delay = 5'd0;
    awvalid = 1'b1; awid = 4'd1; awaddr = 8'h00; awlen = 4'd0;
    tick();
    awvalid = 1'b0; wvalid = 1'b1; wdata = 8'h77; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin tick(); n++; end
    bready = 1'b1; tick(); bready = 1'b0;
    awvalid = 1'b1; awid = 4'd2; awaddr = 8'hFF; awlen = 4'd1;
    tick();
    awvalid = 1'b0; wvalid = 1'b1; wdata = 8'h5A; wlast = 1'b0;
    tick();
    wdata = 8'hC3; wlast = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd2, EXP_WRAP_RESP}) begin
      errors++; $display("[TB] FAIL wrap_bresp: got %b/%h/%b expected 1/2/%b", bvalid, bid, bresp, EXP_WRAP_RESP);
    end
    bready = 1'b1; tick(); bready = 1'b0;
    arvalid = 1'b1; arid = 4'd3; araddr = 8'hFF; arlen = 4'd1;
    tick();
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if ({rdata, rresp, rlast} !== {8'h5A, EXP_WRAP_RESP, 1'b0}) begin
      errors++; $display("[TB] FAIL wrap_beat0: got %h/%b/%b expected 5a/%b/0", rdata, rresp, rlast, EXP_WRAP_RESP);
    end
    rready = 1'b1;
    tick();
    checks++;
    if ({rdata, rresp, rlast} !== {EXP_WRAP_D1, EXP_WRAP_RESP, 1'b1}) begin
      errors++; $display("[TB] FAIL wrap_beat1: got %h/%b/%b expected %h/%b/1", rdata, rresp, rlast, EXP_WRAP_D1, EXP_WRAP_RESP);
    end
    tick();
    rready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_delay();
    test_read_delay();
    test_queue_full();
    test_wlast_early();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
